dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the pipeline MEM stage (CPU) and a memory loader/debug requester.
- Sits between the MEM-stage pipeline register, the loader, and dmem.
- Drives a stall to the hazard unit when the CPU loses arbitration.
- Adds bounded loader bursts and starvation protection; read data is registered with 1-cycle latency.

Parameters:
WIDTH, 32, data and address width
MAX_WAIT, 4, loader cycles ungranted before a forced loader grant (>=1)
BURST_MAX, 4, max consecutive locked loader grants while CPU waits (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset; low on a rising clk edge resets the block
cpu_req  in  1  MEM-stage access request
cpu_we  in  1  CPU write enable
cpu_addr  in  WIDTH  CPU address
cpu_wdata  in  WIDTH  CPU write data
cpu_stall  out  1  cpu_req and not granted this cycle (combinational)
cpu_rdata  out  WIDTH  registered CPU read data
cpu_rvalid  out  1  cpu_rdata valid
ldr_req  in  1  loader request
ldr_lock  in  1  loader requests burst continuation
ldr_we  in  1  loader write enable
ldr_addr  in  WIDTH  loader address
ldr_wdata  in  WIDTH  loader write data
ldr_gnt  out  1  loader granted this cycle (combinational)
ldr_rdata  out  WIDTH  registered loader read data
ldr_rvalid  out  1  ldr_rdata valid
mem_we  out  1  to dmem
mem_addr  out  WIDTH  to dmem
mem_wdata  out  WIDTH  to dmem
mem_rdata  in  WIDTH  dmem combinational read data

Behaviour:
- Reset (reset==0 at edge): state=ARB_IDLE, wait_cnt=0, beat_cnt=0, cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0. Combinational outputs follow current inputs and state.
- One access per cycle. Grant is combinational, evaluated in priority order:
  1. state==ARB_LDR & ldr_req & ldr_lock & beat_cnt<BURST_MAX-1 -> loader
  2. ldr_req & wait_cnt==MAX_WAIT -> loader
  3. cpu_req -> CPU
  4. ldr_req -> loader
  5. else -> none
- mem_* follow the winner's we/addr/wdata. With no grant, mem_we=0, mem_addr=0, mem_wdata=0.
- cpu_stall = cpu_req & ~cpu_grant. ldr_gnt = loader grant.
- State at edge: ARB_CPU if CPU granted, ARB_LDR if loader granted, else ARB_IDLE.
- beat_cnt: +1 on loader grant when state==ARB_LDR; set to 0 on a loader grant from another state; 0 when the loader is not granted. Saturates at BURST_MAX-1.
- wait_cnt: +1 (saturating at MAX_WAIT) when ldr_req & ~ldr_gnt; cleared on loader grant or ldr_req==0.
- Read latency 1: a granted read (we=0) at cycle N captures mem_rdata into the winner's rdata at the N edge; that rvalid=1 in cycle N+1 only.
- Writes never assert rvalid. An rdata register holds its value until the next read by its owner.
- Boundaries:
  - Simultaneous requests with wait_cnt<MAX_WAIT: CPU wins.
  - Lock without a CPU request continues indefinitely; beat_cnt saturates and rule 4 applies.
  - Lock dropped mid-burst: normal priority next cycle.
  - Loader winning by starvation while CPU requests: exactly one loader beat, unless rule 1 applies next cycle.
  - Reset mid-burst or with a read outstanding: same-edge return to reset values, and a pending rvalid is suppressed.
  - Requests during reset cycles are not latched.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds outputs stat_cpu_grants, stat_ldr_grants, stat_conflicts (each 32-bit, saturating at 0xFFFFFFFF, reset to 0).
  - stat_conflicts increments when cpu_req & ldr_req in the same cycle.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_CPU, ARB_LDR}
  - typedef enum owner_t {OWN_NONE, OWN_CPU, OWN_LDR}
  - localparam STAT_W=32
- One sub-module, arb_sat_counter (parameterised width and max; inc/clr inputs; synchronous active-low reset). Used for wait_cnt, beat_cnt and the stats counters.

Test Plan:
- Reset held 2 cycles with cpu_req=1 and a read pending -> all rvalid=0, rdata=0, state ARB_IDLE; first cycle after release grants CPU.
- CPU read addr 0x10 where mem_rdata=0xDEADBEEF, no loader -> cpu_stall=0, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; following cycle cpu_rvalid=0.
- cpu_req and ldr_req both held high, MAX_WAIT=4 -> CPU granted 4 cycles, loader granted in the 5th (cpu_stall=1 that cycle), then CPU again; the pattern repeats.
- Loader locked write burst to 0x100..0x10C with cpu_req asserted after the first beat, BURST_MAX=4 -> 4 consecutive loader writes (mem_we=1), cpu_stall=1 for 3 cycles, then CPU granted.
- Loader read 0x20 granted, reset driven low the next edge -> ldr_rvalid stays 0, ldr_rdata=0.
- With DMEM_ARB_STATS_EN, 10 conflict cycles at MAX_WAIT=4 -> stat_conflicts=10, stat_cpu_grants=8, stat_ldr_grants=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant owner, stats width.
// No logic here; imported by the arbiter top.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_LDR  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  localparam int STAT_W = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, loader and dmem signal bundle for the data-memory arbiter.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_stall;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_rvalid;
  logic             ldr_req;
  logic             ldr_lock;
  logic             ldr_we;
  logic [WIDTH-1:0] ldr_addr;
  logic [WIDTH-1:0] ldr_wdata;
  logic             ldr_gnt;
  logic [WIDTH-1:0] ldr_rdata;
  logic             ldr_rvalid;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_lock, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output ldr_gnt, ldr_rdata, ldr_rvalid,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_lock, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  ldr_gnt, ldr_rdata, ldr_rvalid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear (clear wins); latency 1 cycle.
// No backpressure: inc is ignored once the count reaches MAX.
module arb_sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between CPU MEM stage and loader; grant is combinational, read data returns 1 cycle later.
// Backpressure: losing CPU sees cpu_stall, losing loader simply lacks ldr_gnt. Stats ports under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_cpu_grants,
  output logic [STAT_W-1:0]  stat_ldr_grants,
  output logic [STAT_W-1:0]  stat_conflicts
`endif
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } acc_t;

  arb_state_t        state_q, state_d;
  owner_t            owner;
  acc_t              mem_acc;
  logic              cpu_gnt, ldr_gnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;

  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic             ldr_rvalid_q, ldr_rvalid_d;
  logic [WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;

  // Priority: locked burst continuation, starved loader, CPU, loader.
  always_comb begin
    owner = OWN_NONE;
    if ((state_q == ARB_LDR) && bus.ldr_req && bus.ldr_lock &&
        (beat_cnt < BEAT_W'(BURST_MAX - 1))) begin
      owner = OWN_LDR;
    end else if (bus.ldr_req && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
      owner = OWN_LDR;
    end else if (bus.cpu_req) begin
      owner = OWN_CPU;
    end else if (bus.ldr_req) begin
      owner = OWN_LDR;
    end
  end

  assign cpu_gnt = (owner == OWN_CPU);
  assign ldr_gnt = (owner == OWN_LDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ARB_IDLE;
    case (owner)
      OWN_CPU: state_d = ARB_CPU;
      OWN_LDR: state_d = ARB_LDR;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_acc = '0;
    if (cpu_gnt) begin
      mem_acc = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    end else if (ldr_gnt) begin
      mem_acc = '{we: bus.ldr_we, addr: bus.ldr_addr, wdata: bus.ldr_wdata};
    end
  end

  assign bus.mem_we    = mem_acc.we;
  assign bus.mem_addr  = mem_acc.addr;
  assign bus.mem_wdata = mem_acc.wdata;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.ldr_gnt   = ldr_gnt;

  arb_sat_counter #(.W(WAIT_W), .MAX(WAIT_W'(MAX_WAIT))) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.ldr_req & ~ldr_gnt),
    .clr   (~(bus.ldr_req & ~ldr_gnt)),
    .cnt   (wait_cnt)
  );

  // Any cycle that is not a continued loader beat restarts the burst count.
  arb_sat_counter #(.W(BEAT_W), .MAX(BEAT_W'(BURST_MAX - 1))) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ldr_gnt & (state_q == ARB_LDR)),
    .clr   (~(ldr_gnt & (state_q == ARB_LDR))),
    .cnt   (beat_cnt)
  );

  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
    ldr_rvalid_d = ldr_gnt & ~bus.ldr_we;
    ldr_rdata_d  = ldr_rvalid_d ? bus.mem_rdata : ldr_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rvalid_q <= 1'b0;
      ldr_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.ldr_rdata  = ldr_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_stat_cpu (
    .clk (clk), .reset (reset), .inc (cpu_gnt), .clr (1'b0), .cnt (stat_cpu_grants)
  );

  arb_sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_stat_ldr (
    .clk (clk), .reset (reset), .inc (ldr_gnt), .clr (1'b0), .cnt (stat_ldr_grants)
  );

  arb_sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_stat_conf (
    .clk (clk), .reset (reset), .inc (bus.cpu_req & bus.ldr_req), .clr (1'b0),
    .cnt (stat_conflicts)
  );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic against a rule-level model.
// Build with DMEM_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_dmem_arbiter;
  localparam int W  = 32;
  localparam int MW = 4;
  localparam int BM = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dmem_arbiter_if #(.WIDTH(W)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_cpu, st_ldr, st_conf;
`endif

  dmem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .BURST_MAX(BM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_grants (st_cpu),
    .stat_ldr_grants (st_ldr),
    .stat_conflicts  (st_conf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who won last cycle, length of the current loader run,
  // how long the loader has been kept waiting, and the last read results.
  int          prev_win = 0;   // 0 none, 1 cpu, 2 loader
  int          ldr_run  = 0;
  int          ldr_miss = 0;
  int          cur_win  = 0;
  logic        m_cpu_rv = 1'b0, m_ldr_rv = 1'b0;
  logic [31:0] m_cpu_rd = '0, m_ldr_rd = '0;
  int          s_cpu = 0, s_ldr = 0, s_conf = 0;

  // Drive one cycle's inputs at the falling edge and check everything visible before the next rising edge.
  task automatic drive(input logic rst_n, input logic cr, input logic cwe,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input logic lr, input logic ll, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd,
                       input logic [31:0] mrd);
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    reset = rst_n;
    bus.cpu_req = cr;  bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
    bus.ldr_req = lr;  bus.ldr_lock = ll; bus.ldr_we = lwe;
    bus.ldr_addr = la; bus.ldr_wdata = lwd;
    bus.mem_rdata = mrd;
    #1;
    if (prev_win == 2 && lr && ll && ldr_run < BM) cur_win = 2;
    else if (lr && ldr_miss >= MW)                 cur_win = 2;
    else if (cr)                                   cur_win = 1;
    else if (lr)                                   cur_win = 2;
    else                                           cur_win = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (cur_win == 1) begin e_we = cwe; e_addr = ca; e_wdata = cwd; end
    if (cur_win == 2) begin e_we = lwe; e_addr = la; e_wdata = lwd; end
    check_val("ldr_gnt",    {31'd0, bus.ldr_gnt},   {31'd0, cur_win == 2});
    check_val("cpu_stall",  {31'd0, bus.cpu_stall}, {31'd0, cr && cur_win != 1});
    check_val("mem_we",     {31'd0, bus.mem_we},    {31'd0, e_we});
    check_val("mem_addr",   bus.mem_addr,           e_addr);
    check_val("mem_wdata",  bus.mem_wdata,          e_wdata);
    check_val("cpu_rvalid", {31'd0, bus.cpu_rvalid}, {31'd0, m_cpu_rv});
    check_val("cpu_rdata",  bus.cpu_rdata,          m_cpu_rd);
    check_val("ldr_rvalid", {31'd0, bus.ldr_rvalid}, {31'd0, m_ldr_rv});
    check_val("ldr_rdata",  bus.ldr_rdata,          m_ldr_rd);
  endtask

  task automatic commit();
    @(posedge clk);
    if (!reset) begin
      prev_win = 0; ldr_run = 0; ldr_miss = 0;
      m_cpu_rv = 1'b0; m_ldr_rv = 1'b0; m_cpu_rd = '0; m_ldr_rd = '0;
      s_cpu = 0; s_ldr = 0; s_conf = 0;
    end else begin
      ldr_run  = (cur_win == 2) ? ((prev_win == 2) ? ldr_run + 1 : 1) : 0;
      ldr_miss = (bus.ldr_req && cur_win != 2) ? ldr_miss + 1 : 0;
      m_cpu_rv = (cur_win == 1) && !bus.cpu_we;
      m_ldr_rv = (cur_win == 2) && !bus.ldr_we;
      if (m_cpu_rv) m_cpu_rd = bus.mem_rdata;
      if (m_ldr_rv) m_ldr_rd = bus.mem_rdata;
      if (cur_win == 1) s_cpu++;
      if (cur_win == 2) s_ldr++;
      if (bus.cpu_req && bus.ldr_req) s_conf++;
      prev_win = cur_win;
    end
  endtask

  task automatic step(input logic rst_n, input logic cr, input logic cwe,
                      input logic [31:0] ca, input logic [31:0] cwd,
                      input logic lr, input logic ll, input logic lwe,
                      input logic [31:0] la, input logic [31:0] lwd,
                      input logic [31:0] mrd);
    drive(rst_n, cr, cwe, ca, cwd, lr, ll, lwe, la, lwd, mrd);
    commit();
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_lock = 0; bus.ldr_we = 0; bus.ldr_addr = '0;
    bus.ldr_wdata = '0; bus.mem_rdata = '0;
    // Initial unchecked reset so no register is compared before its first reset edge.
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held two cycles with a CPU read pending, then a CPU read of 0x10.
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'h5A5A5A5A);
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'h5A5A5A5A);
    drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    check_val("tp_stall0", {31'd0, bus.cpu_stall}, 32'd0);
    check_val("tp_addr10", bus.mem_addr, 32'h10);
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111);
    check_val("tp_rvalid1", {31'd0, bus.cpu_rvalid}, 32'd1);
    check_val("tp_rdata",   bus.cpu_rdata, 32'hDEADBEEF);
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222);
    check_val("tp_rvalid0", {31'd0, bus.cpu_rvalid}, 32'd0);
    commit();

    // Conflict pattern: four CPU grants, one starved loader grant, repeating.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 32'h40 + i, 0, 1, 0, 0, 32'h80 + i, 0, $urandom);
      check_val("tp_starve", {31'd0, bus.ldr_gnt}, {31'd0, (i % 5) == 4});
      commit();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
    check_val("stat_conf", st_conf, 32'd10);
    check_val("stat_cpu",  st_cpu,  32'd8);
    check_val("stat_ldr",  st_ldr,  32'd2);
`endif
    commit();

    // Locked write burst 0x100..0x10C, CPU joins after the first beat.
    for (int i = 0; i < 6; i++) begin
      drive(1, i > 0, 0, 32'h200, 0, 1, 1, 1, 32'h100 + 4 * i, 32'hA0 + i, 0);
      check_val("tp_burst_gnt",   {31'd0, bus.ldr_gnt},   {31'd0, i < 4});
      check_val("tp_burst_stall", {31'd0, bus.cpu_stall}, {31'd0, i >= 1 && i < 4});
      commit();
    end

    // Loader read granted on the same edge that reset is asserted.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 0, 32'hCAFEF00D);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("tp_rst_rvalid", {31'd0, bus.ldr_rvalid}, 32'd0);
    check_val("tp_rst_rdata",  bus.ldr_rdata, 32'd0);
    commit();

    // Random traffic with long-held lock and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      logic rn, cr, lr;
      rn = ($urandom_range(0, 99) >= 2);
      cr = ($urandom_range(0, 99) < 55);
      lr = ($urandom_range(0, 99) < 60);
      step(rn, cr, 1'($urandom), $urandom, $urandom,
           lr, ($urandom_range(0, 99) < 70), 1'($urandom), $urandom, $urandom, $urandom);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
    check_val("rnd_stat_conf", st_conf, s_conf);
    check_val("rnd_stat_cpu",  st_cpu,  s_cpu);
    check_val("rnd_stat_ldr",  st_ldr,  s_ldr);
`endif
    commit();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
